// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Owns the single GPU VRAM write port and shares it between the CPU
//   (single-byte writes queued in a small posted-write FIFO, drained only
//   while write_window is high) and a burst fill engine (which holds the GPU
//   in reset while it owns the port and ignores write_window).
//
// Ports:
//   clk_12_5875        GPU pixel clock, all logic on the rising edge
//   rst                synchronous active-high reset
//   cpu_wr_valid/ready CPU posted-write handshake (transfer on valid&ready)
//   cpu_address/data   CPU write address/data
//   fill_req           fill engine requests the port
//   fill_grant         port owned by the fill engine
//   fill_valid         fill beat valid (honoured only while granted)
//   fill_address/data  fill beat address/data
//   fill_done          end of burst (honoured only while granted)
//   write_window       CPU writes permitted this cycle
//   vram_address/data  registered write address/data to gpu_m
//   vram_write_enable  one-cycle write pulse to gpu_m
//   gpu_hold           high while the fill engine owns the port
//   fifo_count         current CPU FIFO occupancy
module vram_write_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_12_5875,
  input  logic                          rst,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_WIDTH-1:0]         cpu_address,
  input  logic [DATA_WIDTH-1:0]         cpu_data,
  input  logic                          fill_req,
  output logic                          fill_grant,
  input  logic                          fill_valid,
  input  logic [ADDR_WIDTH-1:0]         fill_address,
  input  logic [DATA_WIDTH-1:0]         fill_data,
  input  logic                          fill_done,
  input  logic                          write_window,
  output logic [ADDR_WIDTH-1:0]         vram_address,
  output logic [DATA_WIDTH-1:0]         vram_data,
  output logic                          vram_write_enable,
  output logic                          gpu_hold,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_next;
  logic                  cooldown;
  logic                  push, pop, fill_wr;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

  assign cpu_wr_ready = !rst && (fifo_count != CW'(FIFO_DEPTH));
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign fill_grant   = (state == FILL);
  assign gpu_hold     = (state == FILL);

  // Source selection: fill_req beats the FIFO in IDLE, except in the single
  // IDLE cycle right after a burst, which is left to the FIFO so a fill
  // engine that keeps fill_req high cannot starve queued CPU writes.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    fill_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (fill_req && !cooldown) begin
          state_next = FILL;
        end else if ((fifo_count != '0) && write_window) begin
          pop = 1'b1;
        end
      end
      FILL: begin
        fill_wr = fill_valid;
        if (fill_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      state    <= IDLE;
      cooldown <= 1'b0;
    end else begin
      state    <= state_next;
      cooldown <= (state == FILL) && (state_next == IDLE);
    end
  end

  // CPU posted-write FIFO; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_12_5875) begin
    if (push) begin
      addr_mem[wr_ptr] <= cpu_address;
      data_mem[wr_ptr] <= cpu_data;
    end
  end

  // Output register stage: selected write appears on the port one cycle later
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      vram_write_enable <= 1'b0;
      vram_address      <= '0;
      vram_data         <= '0;
    end else begin
      vram_write_enable <= pop || fill_wr;
      if (fill_wr) begin
        vram_address <= fill_address;
        vram_data    <= fill_data;
      end else if (pop) begin
        vram_address <= addr_mem[rd_ptr];
        vram_data    <= data_mem[rd_ptr];
      end
    end
  end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Owns the single GPU VRAM write port (address/data/write_enable into gpu_m) and shares it between two requesters.
- Requester 1 is the CPU, which posts single-byte writes through a small FIFO. These are drained only while write_window is high, e.g. vblank.
- Requester 2 is a burst fill engine (fill_vram-style). While it owns the port it holds the GPU in reset, and its writes ignore write_window.
- Sits between the bus/fill logic and gpu_m; gpu_hold is ORed into the GPU reset by the top level.

Parameters:
- ADDR_WIDTH, 12, VRAM address width (matches VRAM_ADDR_WIDTH).
- DATA_WIDTH, 8, VRAM data width.
- FIFO_DEPTH, 4, CPU posted-write FIFO entries; power of two, ≥2.

Ports:
- clk_12_5875  in  1  GPU pixel clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  FIFO can accept; transfer on valid&ready.
- cpu_address  in  ADDR_WIDTH  CPU write address.
- cpu_data  in  DATA_WIDTH  CPU write data.
- fill_req  in  1  fill engine requests port; held high until fill_grant.
- fill_grant  out  1  port owned by fill engine.
- fill_valid  in  1  fill beat valid (honoured only while fill_grant).
- fill_address  in  ADDR_WIDTH  fill beat address.
- fill_data  in  DATA_WIDTH  fill beat data.
- fill_done  in  1  last beat / end of burst (honoured only while fill_grant).
- write_window  in  1  CPU writes to VRAM permitted this cycle.
- vram_address  out  ADDR_WIDTH  to gpu_m address.
- vram_data  out  DATA_WIDTH  to gpu_m data.
- vram_write_enable  out  1  to gpu_m write_enable; one-cycle pulse per write.
- gpu_hold  out  1  high while fill owns the port; ORed into the GPU reset.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- **Reset** (rst high at an edge):
  - State goes to IDLE and the FIFO is emptied.
  - Outputs reset to: fifo_count=0, fill_grant=0, gpu_hold=0, vram_write_enable=0, vram_address=0, vram_data=0.
  - cpu_wr_ready is 0 while rst is high.
  - Reset mid-fill or mid-drain aborts immediately. No further writes are issued and queued entries are lost.
- **CPU FIFO:**
  - cpu_wr_ready = !rst && (fifo_count != FIFO_DEPTH). This is combinational and does not depend on a same-cycle pop.
  - A push occurs on cpu_wr_valid&cpu_wr_ready. Order is strict FIFO.
  - Push and pop in the same cycle leaves fifo_count unchanged.
  - Pushes are accepted in every state, including FILL.
- **Output registers:**
  - vram_* are registered. A write selected in cycle N appears with vram_write_enable=1 in cycle N+1.
  - In cycles with no write, vram_write_enable=0 and vram_address/vram_data hold their last values.
- **States:**
  - IDLE:
    - If fill_req, go to FILL; fill_grant and gpu_hold go high next cycle. fill_req has priority over the FIFO; no pop occurs in the transition cycle.
    - Otherwise, if FIFO non-empty and write_window is high, pop one entry per cycle. Drain is back-to-back while the window stays high.
    - write_window is sampled in the pop cycle. A pop in the last window cycle is still written in the following cycle.
  - FILL (fill_grant=1, gpu_hold=1):
    - Each cycle with fill_valid issues a write of fill_address/fill_data. write_window is ignored.
    - fill_done goes to IDLE; fill_grant and gpu_hold drop next cycle. If fill_valid accompanies fill_done, that beat is written.
    - fill_req is ignored in FILL. After returning to IDLE, fill_req still high re-grants after one IDLE cycle; the FIFO may pop in that IDLE cycle.
- **No-collision guarantee:** exactly one source is selected per cycle.
- **Counter width:** fifo_count never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. **Reset values:** rst=1 for 2 cycles with cpu_wr_valid=1 → cpu_wr_ready=0, fifo_count=0, vram_write_enable=0, fill_grant=0, gpu_hold=0.
2. **Single CPU write:** write_window=1, push addr 0x800 data 0x0F → fifo_count 1 for one cycle. vram_write_enable pulses one cycle with vram_address=0x800, vram_data=0x0F, two cycles after the push edge.
3. **FIFO full then drain:** write_window=0, push 0x800..0x804 data 0x0F,0x0F,0x00,0x07,0x55 → first 4 accepted; cpu_wr_ready=0 on the fifth, fifo_count=4. Raise write_window → 4 consecutive pulses with addresses 0x800..0x803 in order. Fifth write accepted after the first pop.
4. **Fill burst outside window:** write_window=0, fill_req=1 → fill_grant/gpu_hold high next cycle. 8 beats to 0x000..0x007 data 0x0F, done on the last beat → 8 pulses; grant/hold drop the cycle after done.
5. **Fill priority over queued CPU data:** FIFO holds 2 entries, write_window=1, fill_req=1 in the same IDLE cycle → FILL entered, no CPU pop. CPU entries drain only after fill_done; pushes during FILL are accepted.
6. **Reset mid-fill:** assert rst during FILL after 3 beats with FIFO non-empty → next cycle fill_grant=0, gpu_hold=0, fifo_count=0, no further vram_write_enable.
